// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared state, marker and table-entry types for the I2C init sequencer
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_WAIT_LATCH1,
        ST_WAIT_LATCH2,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_GAP,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } seq_state_e;

    localparam logic [7:0] DELAY_MARKER = 8'hFF;

    typedef struct packed {
        logic [7:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] val;
    } rom_entry_t;

endpackage

// File: rtl/i2c_init_rom.sv
// rtl/i2c_init_rom.sv - combinational video-transmitter init table, one {dev, reg, val} word per index
module i2c_init_rom #(
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] index_i,
    output logic [23:0]      entry_o
);

    // Unlisted indices read as a zero-length delay, which the sequencer skips.
    always_comb begin
        case (32'(index_i))
            0:       entry_o = 24'h72_41_10;
            1:       entry_o = 24'hFF_00_01;
            2:       entry_o = 24'h72_98_03;
            3:       entry_o = 24'h72_9A_E0;
            4:       entry_o = 24'h72_9C_30;
            5:       entry_o = 24'h72_9D_61;
            6:       entry_o = 24'h72_A2_A4;
            7:       entry_o = 24'h72_A3_A4;
            8:       entry_o = 24'h72_E0_D0;
            9:       entry_o = 24'h72_F9_00;
            10:      entry_o = 24'h72_15_00;
            11:      entry_o = 24'h72_16_30;
            12:      entry_o = 24'h72_17_02;
            13:      entry_o = 24'h72_18_46;
            14:      entry_o = 24'h72_AF_16;
            15:      entry_o = 24'h72_BA_60;
            default: entry_o = 24'hFF_00_00;
        endcase
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// rtl/i2c_init_sequencer.sv - walks the init table and drives the I2C controller handshake with retries and delays
module i2c_init_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int  NUM_ENTRIES    = 32,
    parameter int  MAX_RETRIES    = 3,
    parameter int  TIMEOUT_CYCLES = 65535,
    parameter int  GAP_CYCLES     = 270,
    parameter int  DELAY_UNIT     = 27000,
    localparam int IDX_W          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    output logic [IDX_W-1:0] rom_index,
    input  logic [23:0]      rom_entry,
    output logic             i2c_start,
    output logic [7:0]       i2c_address,
    output logic [7:0]       i2c_data,
    output logic             i2c_more,
    input  logic             i2c_busy,
    input  logic             i2c_nack,
    input  logic             i2c_data_saved,
    output logic             seq_busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index
);

    // The walk index must be able to hold NUM_ENTRIES itself to detect the end of the table.
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             nack_seen_q, nack_seen_d;
    logic             timed_out_q, timed_out_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             more_q, more_d;
    logic [IDX_W-1:0] err_index_q, err_index_d;

    rom_entry_t       entry;
    logic             in_wait;
    logic             in_txn;
    logic [TMR_W-1:0] timer_inc;
    logic             timeout;

    assign entry     = rom_entry;
    assign in_wait   = (state_q == ST_WAIT_LATCH1) || (state_q == ST_WAIT_LATCH2) ||
                       (state_q == ST_WAIT_DONE);
    assign in_txn    = in_wait || (state_q == ST_START);
    assign timer_inc = (timer_q == TMR_W'(TIMEOUT_CYCLES)) ? timer_q : timer_q + 1'b1;
    assign timeout   = in_wait && (timer_inc == TMR_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            cnt_q       <= '0;
            nack_seen_q <= 1'b0;
            timed_out_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            more_q      <= 1'b0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            nack_seen_q <= nack_seen_d;
            timed_out_q <= timed_out_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            more_q      <= more_d;
            err_index_q <= err_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        timer_d     = in_wait ? timer_inc : '0;
        cnt_d       = cnt_q;
        nack_seen_d = nack_seen_q || (in_txn && i2c_nack);
        timed_out_d = timed_out_q;
        addr_d      = addr_q;
        data_d      = data_q;
        more_d      = more_q;
        err_index_d = err_index_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (go) begin
                    index_d = '0;
                    retry_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (index_q == CNT_W'(NUM_ENTRIES)) begin
                    state_d = ST_DONE;
                end else if (entry.dev == DELAY_MARKER) begin
                    if (entry.val == 8'h00) begin
                        index_d = index_q + 1'b1;
                    end else begin
                        cnt_d   = 32'(entry.val) * 32'(DELAY_UNIT);
                        state_d = ST_DELAY;
                    end
                end else begin
                    addr_d      = entry.dev;
                    data_d      = entry.reg_addr;
                    nack_seen_d = 1'b0;
                    timed_out_d = 1'b0;
                    state_d     = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT_LATCH1;
            ST_WAIT_LATCH1: begin
                // A data_saved arriving on the timeout cycle still counts as progress.
                if (i2c_data_saved) begin
                    data_d  = entry.val;
                    more_d  = 1'b1;
                    state_d = ST_WAIT_LATCH2;
                end else if (timeout) begin
                    timed_out_d = 1'b1;
                    more_d      = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_WAIT_LATCH2: begin
                if (i2c_data_saved) begin
                    more_d  = 1'b0;
                    state_d = ST_WAIT_DONE;
                end else if (timeout) begin
                    timed_out_d = 1'b1;
                    more_d      = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_WAIT_DONE: begin
                if (!i2c_busy) begin
                    state_d = ST_CHECK;
                end else if (timeout) begin
                    timed_out_d = 1'b1;
                    more_d      = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!nack_seen_q && !timed_out_q) begin
                    retry_d = '0;
                    index_d = index_q + 1'b1;
                    cnt_d   = 32'(GAP_CYCLES);
                    state_d = ST_GAP;
                end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
                    retry_d = retry_q + 1'b1;
                    cnt_d   = 32'(GAP_CYCLES);
                    state_d = ST_GAP;
                end else begin
                    err_index_d = index_q[IDX_W-1:0];
                    state_d     = ST_ERROR;
                end
            end
            ST_GAP: begin
                // Holding here while busy keeps a timed-out transfer from being overlapped by a new start.
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!i2c_busy) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DELAY: begin
                if (cnt_q == 32'd0) begin
                    index_d = index_q + 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_comb begin
        i2c_start = 1'b0;
        seq_busy  = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            ST_IDLE:  seq_busy = 1'b0;
            ST_START: i2c_start = 1'b1;
            ST_DONE: begin
                seq_busy = 1'b0;
                done     = 1'b1;
            end
            ST_ERROR: begin
                seq_busy = 1'b0;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    assign rom_index   = index_q[IDX_W-1:0];
    assign i2c_address = addr_q;
    assign i2c_data    = data_q;
    assign i2c_more    = more_q;
    assign err_index   = err_index_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb/tb_i2c_init_sequencer.sv - drives the sequencer with an I2C controller model and compares against a table-walk model
module tb_i2c_init_sequencer;

    localparam int N    = 6;
    localparam int MAXR = 3;
    localparam int TMO  = 50;
    localparam int GAP  = 8;
    localparam int DU   = 20;
    localparam int IW   = 3;

    localparam int F_ACK    = 0;
    localparam int F_NACK   = 1;
    localparam int F_NOSAVE = 2;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] v;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [IW-1:0] rom_index;
    logic [23:0]   rom_entry;
    logic [23:0]   rom_out;
    logic          i2c_start;
    logic [7:0]    i2c_address;
    logic [7:0]    i2c_data;
    logic          i2c_more;
    logic          i2c_busy = 1'b0;
    logic          i2c_nack = 1'b0;
    logic          i2c_data_saved = 1'b0;
    logic          seq_busy;
    logic          done;
    logic          error;
    logic [IW-1:0] err_index;
    logic          use_rom = 1'b0;

    logic [23:0] table_mem [0:7];
    int          fates [0:127];
    int          fate_ptr = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   exp_gap[$];
    int   obs_cyc[$];
    logic exp_err;
    int   exp_eidx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rom_entry = use_rom ? rom_out : table_mem[rom_index];

    i2c_init_sequencer #(
        .NUM_ENTRIES   (N),
        .MAX_RETRIES   (MAXR),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP),
        .DELAY_UNIT    (DU)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .rom_index     (rom_index),
        .rom_entry     (rom_entry),
        .i2c_start     (i2c_start),
        .i2c_address   (i2c_address),
        .i2c_data      (i2c_data),
        .i2c_more      (i2c_more),
        .i2c_busy      (i2c_busy),
        .i2c_nack      (i2c_nack),
        .i2c_data_saved(i2c_data_saved),
        .seq_busy      (seq_busy),
        .done          (done),
        .error         (error),
        .err_index     (err_index)
    );

    i2c_init_rom #(.IDX_W(IW)) rom (
        .index_i(rom_index),
        .entry_o(rom_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_table(input logic [23:0] e0, e1, e2, e3, e4, e5);
        table_mem[0] = e0; table_mem[1] = e1; table_mem[2] = e2;
        table_mem[3] = e3; table_mem[4] = e4; table_mem[5] = e5;
        table_mem[6] = 24'h0; table_mem[7] = 24'h0;
    endtask

    task automatic fill_fates(input int kind);
        for (int i = 0; i < 128; i++) fates[i] = kind;
    endtask

    // Walk the table as the rules describe: skip/accumulate delays, one attempt per fate, retry budget per entry.
    task automatic predict();
        int   idx = 0;
        int   retry = 0;
        int   ticks = 0;
        int   fp = 0;
        int   f;
        bit   first = 1'b1;
        logic [23:0] e;
        txn_t t;
        exp_q.delete(); exp_gap.delete();
        exp_err = 1'b0; exp_eidx = 0;
        while (idx < N) begin
            e = table_mem[idx];
            if (e[23:16] == 8'hFF) begin
                ticks += int'(e[7:0]);
                idx++;
            end else begin
                f = fates[fp];
                fp++;
                t = {e[23:16], (f == F_NOSAVE) ? 16'h0 : e[15:0]};
                exp_q.push_back(t);
                exp_gap.push_back(first ? 0 : ticks * DU + GAP);
                first = 1'b0;
                ticks = 0;
                if (f == F_ACK) begin
                    retry = 0;
                    idx++;
                end else if (retry < MAXR) begin
                    retry++;
                end else begin
                    exp_err  = 1'b1;
                    exp_eidx = idx;
                    break;
                end
            end
        end
    endtask

    task automatic run_seq(input bit abort_l2, output bit aborted);
        int   phase = 0;
        int   cnt = 0;
        int   f = F_ACK;
        int   budget = 0;
        txn_t cur = '0;
        obs_q.delete(); obs_cyc.delete();
        aborted  = 1'b0;
        fate_ptr = 0;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        while (!(done || error) && budget < 4000) begin
            i2c_data_saved = 1'b0;
            i2c_nack       = 1'b0;
            if (i2c_start) begin
                check("start_while_busy", i2c_busy, 1'b0);
                f = fates[fate_ptr];
                fate_ptr++;
                cur = {i2c_address, 16'h0};
                obs_cyc.push_back(cyc);
                i2c_busy = 1'b1;
                phase = 1;
                cnt = $urandom_range(1, 4);
            end else begin
                case (phase)
                    1: begin
                        cnt = cnt - 1;
                        if (cnt == 0) begin
                            if (f == F_NOSAVE) begin
                                obs_q.push_back(cur);
                                phase = 4;
                                cnt = TMO + 10;
                            end else begin
                                cur.r = i2c_data;
                                i2c_data_saved = 1'b1;
                                phase = 2;
                                cnt = $urandom_range(1, 4);
                            end
                        end
                    end
                    2: begin
                        if (abort_l2) begin
                            check("more_in_latch2", i2c_more, 1'b1);
                            reset = 1'b1;
                            #1;
                            check("reset_mid_txn", {i2c_start, i2c_address, i2c_data, i2c_more, seq_busy,
                                                    done, error, err_index, rom_index}, 32'h0);
                            aborted = 1'b1;
                            break;
                        end
                        cnt = cnt - 1;
                        if (cnt == 0) begin
                            check("more_before_value", i2c_more, 1'b1);
                            cur.v = i2c_data;
                            i2c_data_saved = 1'b1;
                            phase = 3;
                            cnt = $urandom_range(1, 4);
                        end
                    end
                    3: begin
                        cnt = cnt - 1;
                        if (cnt == 0) begin
                            check("more_after_value", i2c_more, 1'b0);
                            i2c_busy = 1'b0;
                            i2c_nack = (f == F_NACK);
                            obs_q.push_back(cur);
                            phase = 0;
                        end
                    end
                    4: begin
                        cnt = cnt - 1;
                        if (cnt == 0) begin
                            i2c_busy = 1'b0;
                            phase = 0;
                        end
                    end
                    default: ;
                endcase
            end
            @(negedge clk);
            budget++;
        end
        if (budget >= 4000) check("run_budget", 1'b0, 1'b1);
        i2c_busy = 1'b0;
        i2c_nack = 1'b0;
        i2c_data_saved = 1'b0;
        if (aborted) begin
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic verify(input string name);
        check({name, "/attempts"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            check({name, "/txn"}, obs_q[k], exp_q[k]);
            if (k > 0) check({name, "/spacing"}, (obs_cyc[k] - obs_cyc[k-1]) >= exp_gap[k], 1'b1);
        end
        check({name, "/done"}, done, !exp_err);
        check({name, "/error"}, error, exp_err);
        check({name, "/seq_busy"}, seq_busy, 1'b0);
        if (exp_err) check({name, "/err_index"}, err_index, exp_eidx);
        else         check({name, "/rom_index"}, rom_index, N);
    endtask

    task automatic scenario(input string name);
        bit ab;
        predict();
        run_seq(1'b0, ab);
        verify(name);
    endtask

    initial begin
        bit ab;
        set_table(24'h724110, 24'h729803, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000);
        repeat (3) @(negedge clk);
        check("reset_outputs", {i2c_start, i2c_address, i2c_data, i2c_more, seq_busy, done, error,
                                err_index, rom_index}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {seq_busy, done, error}, 3'b000);

        fill_fates(F_ACK);
        scenario("two_writes");

        fill_fates(F_ACK);
        fates[1] = F_NACK; fates[2] = F_NACK;
        scenario("retry_then_ok");

        fill_fates(F_NACK);
        scenario("nack_exhaust");
        fill_fates(F_ACK);
        scenario("restart_after_error");

        set_table(24'h724110, 24'hFF0002, 24'h729803, 24'hFF0000, 24'hFF0000, 24'hFF0000);
        scenario("delay_entry");

        set_table(24'h724110, 24'h729803, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000);
        fill_fates(F_NOSAVE);
        scenario("latch_timeout");
        if (obs_cyc.size() > 1) check("timeout_len", (obs_cyc[1] - obs_cyc[0]) >= TMO + GAP, 1'b1);

        fill_fates(F_ACK);
        run_seq(1'b1, ab);
        check("abort_reached", ab, 1'b1);
        scenario("replay_after_reset");

        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) table_mem[i] = {8'hFF, 8'h00, 8'($urandom_range(0, 3))};
                else table_mem[i] = {7'($urandom), 1'b0, 16'($urandom)};
            end
            for (int i = 0; i < 128; i++) begin
                int r = $urandom_range(0, 9);
                fates[i] = (r < 7) ? F_ACK : (r < 9) ? F_NACK : F_NOSAVE;
            end
            scenario("random");
        end

        use_rom = 1'b1;
        set_table(24'h724110, 24'hFF0001, 24'h729803, 24'h729AE0, 24'h729C30, 24'h729D61);
        fill_fates(F_ACK);
        scenario("rom_table");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
